// File: rtl/ula_pkg.sv
// Shared constants for the bit-serial ALU: opcodes, FSM encoding and default width.
package ula_pkg;

    localparam int unsigned ULA_WIDTH = 8;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLE  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/ula_serial_slice.sv
// One-bit full adder; B can be inverted (subtract) or forced to zero (pass A).
module ula_serial_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic b_inv,
    input  logic b_zero,
    output logic sum_c,
    output logic cout_c
);

    logic b_eff;

    always_comb begin
        b_eff  = b_zero ? 1'b0 : (b ^ b_inv);
        sum_c  = a ^ b_eff ^ cin;
        cout_c = (a & b_eff) | (a & cin) | (b_eff & cin);
    end

endmodule

// File: rtl/ula_serial.sv
// Bit-serial ALU sequencer: one operand bit per clock, LSB first, through a single slice.
module ula_serial
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = ULA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n, res_q, res_n, f_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [1:0]       op_q, op_n;
    logic             c_q, c_n, z_q, z_n, v_q, v_n;
    logic             busy_n, done_n, carry_n, overflow_n, zero_n;
    logic             sum_c, cout_c, b_inv_c, b_zero_c;

    always_comb begin
        b_inv_c  = (op_q == OP_SUB) || (op_q == OP_SLE);
        b_zero_c = (op_q == OP_PASS);
    end

    ula_serial_slice u_slice (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .cin    (c_q),
        .b_inv  (b_inv_c),
        .b_zero (b_zero_c),
        .sum_c  (sum_c),
        .cout_c (cout_c)
    );

    // Next-state and next-register values; outputs only move on the FINISH edge.
    always_comb begin
        state_next = state;
        a_n        = a_q;
        b_n        = b_q;
        res_n      = res_q;
        cnt_n      = cnt_q;
        op_n       = op_q;
        c_n        = c_q;
        z_n        = z_q;
        v_n        = v_q;
        f_n        = F;
        carry_n    = carry;
        overflow_n = overflow;
        zero_n     = zero;
        done_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_n        = A;
                    b_n        = B;
                    op_n       = op;
                    c_n        = (op == OP_SUB) || (op == OP_SLE);
                    z_n        = 1'b1;
                    v_n        = 1'b0;
                    cnt_n      = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_n   = a_q >> 1;
                b_n   = b_q >> 1;
                res_n = {sum_c, res_q[WIDTH-1:1]};
                c_n   = cout_c;
                z_n   = z_q & ~sum_c;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    v_n        = c_q ^ cout_c;
                    state_next = ST_FINISH;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            ST_FINISH: begin
                // Signed A<=B from the subtract flags: (N ^ V) | Z.
                if (op_q == OP_SLE) begin
                    f_n = {{(WIDTH-1){1'b0}}, (res_q[WIDTH-1] ^ v_q) | z_q};
                end else begin
                    f_n = res_q;
                end
                carry_n    = c_q;
                overflow_n = v_q;
                zero_n     = z_q;
                done_n     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        busy_n = (state_next != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            F        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            a_q      <= a_n;
            b_q      <= b_n;
            res_q    <= res_n;
            cnt_q    <= cnt_n;
            op_q     <= op_n;
            c_q      <= c_n;
            z_q      <= z_n;
            v_q      <= v_n;
            F        <= f_n;
            carry    <= carry_n;
            overflow <= overflow_n;
            zero     <= zero_n;
            done     <= done_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_ula_serial.sv
// Directed bench for ula_serial: arithmetic reference model checked every cycle plus literal pins.
module tb_ula_serial;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy, done, carry, overflow, zero;
    logic [W-1:0] F;

    int checks = 0;
    int errors = 0;
    int dcount = 0;

    ula_serial #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .F        (F),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] f;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    // Reference result straight from two's-complement arithmetic.
    function automatic res_t expect_of(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t     r;
        logic [W:0] s;
        case (o)
            2'b00: begin
                s   = {1'b0, a} + {1'b0, b};
                r.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            2'b01, 2'b10: begin
                s   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r.v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            default: begin
                s   = {1'b0, a};
                r.v = 1'b0;
            end
        endcase
        r.c = s[W];
        r.z = (s[W-1:0] == '0);
        if (o == 2'b10) r.f = ($signed(a) <= $signed(b)) ? W'(1) : W'(0);
        else            r.f = s[W-1:0];
        return r;
    endfunction

    // Model: an accepted start yields results WIDTH+1 edges later with a one-cycle done.
    int   m_cnt  = 0;
    logic m_done = 1'b0;
    res_t m_out  = '0;
    res_t m_pend = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_out  = '0;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_pend = expect_of(op, A, B);
                    m_cnt  = W + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_out  = m_pend;
                    m_done = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("cyc_busy",     32'(busy),     32'(m_cnt != 0));
        check("cyc_done",     32'(done),     32'(m_done));
        check("cyc_F",        32'(F),        32'(m_out.f));
        check("cyc_carry",    32'(carry),    32'(m_out.c));
        check("cyc_overflow", 32'(overflow), 32'(m_out.v));
        check("cyc_zero",     32'(zero),     32'(m_out.z));
        if (done === 1'b1) dcount++;
    end

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles", cyc);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
        @(negedge clock);
        start_op(o, a, b);
        wait_done(cyc);
    endtask

    initial begin
        int cyc;
        int d0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_F", 32'(F), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset = 1'b1;

        run_op(2'b00, 8'h7F, 8'h01, cyc);
        check("add_lat", 32'(cyc), 32'd9);
        check("add_F", 32'(F), 32'h80);
        check("add_c", 32'(carry), 32'h0);
        check("add_v", 32'(overflow), 32'h1);
        check("add_z", 32'(zero), 32'h0);

        run_op(2'b01, 8'h05, 8'h05, cyc);
        check("subz_F", 32'(F), 32'h00);
        check("subz_z", 32'(zero), 32'h1);
        check("subz_c", 32'(carry), 32'h1);
        check("subz_v", 32'(overflow), 32'h0);

        run_op(2'b01, 8'h03, 8'h05, cyc);
        check("subb_F", 32'(F), 32'hFE);
        check("subb_c", 32'(carry), 32'h0);
        check("subb_z", 32'(zero), 32'h0);

        run_op(2'b10, 8'h80, 8'h7F, cyc);
        check("sle_80_7f", 32'(F), 32'h01);
        run_op(2'b10, 8'h05, 8'h05, cyc);
        check("sle_5_5", 32'(F), 32'h01);
        run_op(2'b10, 8'h06, 8'h05, cyc);
        check("sle_6_5", 32'(F), 32'h00);
        run_op(2'b10, 8'h7F, 8'h80, cyc);
        check("sle_7f_80", 32'(F), 32'h00);

        // Start pulsed mid-operation must be ignored.
        @(negedge clock);
        d0 = dcount;
        start_op(2'b00, 8'h10, 8'h20);
        @(negedge clock);
        op = 2'b01; A = 8'hFF; B = 8'h01; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc);
        check("ign_F", 32'(F), 32'h30);

        // Back-to-back: start held during the done cycle.
        start_op(2'b11, 8'hA5, 8'h3C);
        wait_done(cyc);
        check("b2b_lat", 32'(cyc), 32'd9);
        check("b2b_F", 32'(F), 32'hA5);
        #1;
        check("b2b_dones", 32'(dcount - d0), 32'd2);

        // Reset after E4 abandons the operation.
        @(negedge clock);
        start_op(2'b00, 8'h01, 8'h01);
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_F", 32'(F), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        d0 = dcount;
        repeat (3) @(negedge clock);
        check("mid_rst_nodone", 32'(dcount - d0), 32'd0);
        reset = 1'b1;
        start_op(2'b00, 8'h01, 8'h01);
        wait_done(cyc);
        check("post_rst_lat", 32'(cyc), 32'd9);
        check("post_rst_F", 32'(F), 32'h02);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
